// File: rtl/score_event_gen_if.sv
// Bundle between the pipe/game logic and the score event generator.
// The master side drives pipe position and game state; the slave side returns the score outputs.
interface score_event_gen_if #(
   parameter int TOTAL_W = 8
);
   logic               pipe_valid;
   logic [3:0]         pipe_col;
   logic               shift;
   logic               game_over;
   logic               score_inc;
   logic [TOTAL_W-1:0] pass_total;
   logic               dead;

   modport master (
      output pipe_valid,
      output pipe_col,
      output shift,
      output game_over,
      input  score_inc,
      input  pass_total,
      input  dead
   );

   modport slave (
      input  pipe_valid,
      input  pipe_col,
      input  shift,
      input  game_over,
      output score_inc,
      output pass_total,
      output dead
   );
endinterface

// File: rtl/score_event_gen.sv
// Emits one single-cycle score pulse each time a pipe crosses the bird's column while the game is live.
// It also keeps a saturating count of passed pipes for debug display.
module score_event_gen #(
   parameter logic [3:0] BIRD_COL = 4'd5,
   parameter int         TOTAL_W  = 8
) (
   input logic               clk,
   input logic               reset,
   score_event_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      WAIT,
      ARMED,
      SCORED,
      DEAD
   } stateE;

   stateE              state_q, state_d;
   logic               scoreInc_q, scoreInc_d;
   logic [TOTAL_W-1:0] passTotal_q, passTotal_d;
   logic               dead_q, dead_d;

   // State and all outputs are registered together, so score_inc is one cycle wide.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WAIT;
         scoreInc_q  <= 1'b0;
         passTotal_q <= '0;
         dead_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         scoreInc_q  <= scoreInc_d;
         passTotal_q <= passTotal_d;
         dead_q      <= dead_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q != DEAD && bus.game_over) begin
         state_d = DEAD;
      end else begin
         case (state_q)
            WAIT: begin
               if (bus.pipe_valid && (bus.pipe_col > BIRD_COL)) state_d = ARMED;
            end
            ARMED: begin
               if (!bus.pipe_valid)                                 state_d = WAIT;
               else if (bus.shift && (bus.pipe_col == BIRD_COL))    state_d = SCORED;
            end
            SCORED: begin
               // A pipe back to the right of the bird is a respawn and must re-arm before scoring again.
               if (!bus.pipe_valid)                 state_d = WAIT;
               else if (bus.pipe_col > BIRD_COL)    state_d = ARMED;
            end
            default: state_d = DEAD;
         endcase
      end
   end

   always_comb begin
      scoreInc_d  = 1'b0;
      passTotal_d = passTotal_q;
      dead_d      = (state_d == DEAD);
      if ((state_q == ARMED) && (state_d == SCORED)) begin
         scoreInc_d = 1'b1;
         if (passTotal_q != '1) passTotal_d = passTotal_q + 1'b1;
      end
   end

   assign bus.score_inc  = scoreInc_q;
   assign bus.pass_total = passTotal_q;
   assign bus.dead       = dead_q;

endmodule

// File: tb/tb_score_event_gen.sv
// Directed bench for score_event_gen: a default-width instance plus a TOTAL_W=2 instance share one stimulus.
// A units-digit counter model is fed from the default-width score pulse.
module tb_score_event_gen;

   logic       clk;
   logic       reset;
   logic       pipeValid;
   logic [3:0] pipeCol;
   logic       shiftS;
   logic       gameOver;
   logic [3:0] unitsDigit;
   int         checks;
   int         errors;

   score_event_gen_if #(.TOTAL_W(8)) busBig ();
   score_event_gen_if #(.TOTAL_W(2)) busSmall ();

   assign busBig.pipe_valid   = pipeValid;
   assign busBig.pipe_col     = pipeCol;
   assign busBig.shift        = shiftS;
   assign busBig.game_over    = gameOver;
   assign busSmall.pipe_valid = pipeValid;
   assign busSmall.pipe_col   = pipeCol;
   assign busSmall.shift      = shiftS;
   assign busSmall.game_over  = gameOver;

   score_event_gen #(.BIRD_COL(4'd5), .TOTAL_W(8)) dutBig (
      .clk   (clk),
      .reset (reset),
      .bus   (busBig)
   );

   score_event_gen #(.BIRD_COL(4'd5), .TOTAL_W(2)) dutSmall (
      .clk   (clk),
      .reset (reset),
      .bus   (busSmall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Units digit counter downstream of score_inc: advances on every clock where its input is high.
   always @(posedge clk) begin
      if (reset)                   unitsDigit <= 4'd0;
      else if (busBig.score_inc)   unitsDigit <= (unitsDigit == 4'd9) ? 4'd0 : unitsDigit + 4'd1;
   end

   task automatic applyStimulus(input logic v, input logic [3:0] c, input logic s,
                                input logic g, input logic r);
      @(negedge clk);
      pipeValid = v;
      pipeCol   = c;
      shiftS    = s;
      gameOver  = g;
      reset     = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic doReset(input string tag);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput({tag, "_rst_inc"},   8'(busBig.score_inc),  8'h0);
      checkOutput({tag, "_rst_total"}, 8'(busBig.pass_total), 8'h0);
      checkOutput({tag, "_rst_dead"},  8'(busBig.dead),       8'h0);
   endtask

   // Pipe walks 15 down to 0 with a shift every cycle; a live pass pulses only after the column-5 shift.
   task automatic runPass(input string tag, input logic expectPulse);
      for (int c = 15; c >= 0; c--) begin
         applyStimulus(1'b1, 4'(c), 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("%s_big_inc_c%0d", tag, c), 8'(busBig.score_inc),
                     8'(expectPulse && (c == 5)));
         checkOutput($sformatf("%s_small_inc_c%0d", tag, c), 8'(busSmall.score_inc),
                     8'(expectPulse && (c == 5)));
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      pipeValid = 1'b0;
      pipeCol   = 4'd0;
      shiftS    = 1'b0;
      gameOver  = 1'b0;
      reset     = 1'b1;

      $display("[TB] single pass");
      doReset("t1");
      runPass("t1", 1'b1);
      checkOutput("t1_total", 8'(busBig.pass_total), 8'd1);
      checkOutput("t1_dead",  8'(busBig.dead),       8'd0);

      $display("[TB] three passes into digit counter");
      doReset("t2");
      runPass("t2a", 1'b1);
      runPass("t2b", 1'b1);
      runPass("t2c", 1'b1);
      checkOutput("t2_total", 8'(busBig.pass_total), 8'd3);
      checkOutput("t2_digit", 8'(unitsDigit),        8'd3);

      $display("[TB] game over on scoring shift");
      doReset("t3");
      for (int c = 15; c >= 6; c--) begin
         applyStimulus(1'b1, 4'(c), 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("t3_pre_inc_c%0d", c), 8'(busBig.score_inc), 8'd0);
      end
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
      checkOutput("t3_go_inc",   8'(busBig.score_inc),  8'd0);
      checkOutput("t3_go_dead",  8'(busBig.dead),       8'd1);
      checkOutput("t3_go_total", 8'(busBig.pass_total), 8'd0);
      runPass("t3_after", 1'b0);
      checkOutput("t3_after_dead",  8'(busBig.dead),       8'd1);
      checkOutput("t3_after_total", 8'(busBig.pass_total), 8'd0);

      $display("[TB] valid drop while armed");
      doReset("t4");
      for (int c = 15; c >= 8; c--) applyStimulus(1'b1, 4'(c), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
      checkOutput("t4_drop_inc", 8'(busBig.score_inc), 8'd0);
      applyStimulus(1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
      checkOutput("t4_back_inc", 8'(busBig.score_inc), 8'd0);
      for (int c = 14; c >= 0; c--) begin
         applyStimulus(1'b1, 4'(c), 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("t4_inc_c%0d", c), 8'(busBig.score_inc), 8'(c == 5));
      end
      checkOutput("t4_total", 8'(busBig.pass_total), 8'd1);

      $display("[TB] saturation with TOTAL_W=2");
      doReset("t5");
      for (int p = 1; p <= 5; p++) begin
         runPass($sformatf("t5_p%0d", p), 1'b1);
         checkOutput($sformatf("t5_small_total_p%0d", p), 8'(busSmall.pass_total), 8'((p > 3) ? 3 : p));
         checkOutput($sformatf("t5_big_total_p%0d", p),   8'(busBig.pass_total),   8'(p));
      end

      $display("[TB] reset during pulse");
      doReset("t6");
      for (int c = 15; c >= 5; c--) applyStimulus(1'b1, 4'(c), 1'b1, 1'b0, 1'b0);
      checkOutput("t6_pulse_inc",   8'(busBig.score_inc),  8'd1);
      checkOutput("t6_pulse_total", 8'(busBig.pass_total), 8'd1);
      applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
      checkOutput("t6_rst_inc",   8'(busBig.score_inc),  8'd0);
      checkOutput("t6_rst_total", 8'(busBig.pass_total), 8'd0);
      checkOutput("t6_rst_dead",  8'(busBig.dead),       8'd0);
      applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_wait_inc_a", 8'(busBig.score_inc), 8'd0);
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_wait_inc_b", 8'(busBig.score_inc), 8'd0);
      checkOutput("t6_wait_total", 8'(busBig.pass_total), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_event_gen.md
# score_event_gen

Upstream stage of the score digits: watches the scrolling pipe column and the game-over flag, and emits exactly one single-cycle `score_inc` pulse each time a pipe passes the bird's column while the game is live. `score_inc` drives the `in` input of the least-significant decimal digit counter. That counter advances on every clock where `in` is high, so the pulse width here is a hard requirement. The block also keeps a saturating pass total for debug display.

## Interface
Parameters:
- `BIRD_COL`, default 4'd5: fixed column of the bird on the 16-column playfield. Legal range 1..14.
- `TOTAL_W`, default 8: width of `pass_total`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `pipe_valid`  in  1  a pipe is currently on screen.
- `pipe_col`  in  4  current column of the pipe, 0 = leftmost. It is the value before any shift taking effect at this edge.
- `shift`  in  1  one-cycle strobe: pipes move one column left at this clock edge. Column 0 shifting wraps to 15, i.e. respawn.
- `game_over`  in  1  level. The bird has collided.
- `score_inc`  out  1  one-cycle score pulse to the digit counter.
- `pass_total`  out  TOTAL_W  pipes passed since reset, saturating.
- `dead`  out  1  high once `game_over` has been seen. Cleared only by reset.

## Operation
- FSM states: WAIT, ARMED, SCORED, DEAD. All outputs are registered.
- WAIT goes to ARMED when `pipe_valid` is high and `pipe_col` > `BIRD_COL`, meaning the pipe is to the right of the bird.
- ARMED:
  - `pipe_valid` low goes to WAIT with no pulse.
  - `shift` high with `pipe_col` == `BIRD_COL` goes to SCORED. This asserts `score_inc` for the next cycle and increments `pass_total`.
  - Any other input combination holds ARMED.
- SCORED:
  - `pipe_valid` low goes to WAIT.
  - `pipe_col` > `BIRD_COL` goes to ARMED. This covers a pipe that has respawned at the right.
  - Otherwise the state holds.
  - No further pulse is emitted for the same pipe, however many shifts occur.
- DEAD:
  - Entered from any state on the first clock where `game_over` = 1.
  - `dead` = 1 and `score_inc` = 0.
  - No transitions out except reset.
- Priority at each edge: reset, then `game_over`, then `pipe_valid` low, then the shift/score condition.
  - If `game_over` and a scoring shift occur together, the block goes to DEAD with no pulse and no increment.
- `pass_total` increments by 1 per pulse and saturates at 2^TOTAL_W−1. At saturation `score_inc` still pulses.
- Reset values:
  - state WAIT
  - `score_inc` 0
  - `pass_total` 0
  - `dead` 0
- Reset asserted mid-pulse clears `score_inc` at that edge. The pulse never stretches.

## Timing
- Latency: a scoring shift sampled at edge N gives `score_inc` = 1 from edge N to edge N+1, and 0 after N+1.
  - `pass_total` shows the new value from edge N onward.
  - `score_inc` is never high on two consecutive cycles. The minimum gap between pulses is one full shift cycle, because the respawned pipe must re-arm first.
- Re-arm: a respawn to column 15 at edge M is seen as `pipe_col` = 15 in the cycle after M. The transition to ARMED happens at edge M+1.
- `game_over` sampled high at edge N gives `dead` = 1 from edge N, and `score_inc` = 0 from edge N.
- Inputs are sampled only at the rising edge of `clk`. `shift` is single-cycle; a `shift` held high for several cycles is treated as several shifts.

## Test plan
- Reset, then `pipe_valid` = 1 with `pipe_col` stepping 15 down to 0 via `shift` (BIRD_COL = 5) → exactly one `score_inc` pulse, one cycle wide. The pulse follows the edge where `pipe_col` = 5 and `shift` = 1. `pass_total` = 1.
- Three full pipe passes with respawn to 15 between them, feeding the units digit counter → 3 pulses total, `pass_total` = 3, and the digit counter shows 3.
- `game_over` = 1 on the same edge as the scoring shift → `score_inc` stays 0, `dead` = 1, `pass_total` unchanged. Later shifts produce no pulse until reset.
- `pipe_valid` drops while ARMED with `pipe_col` = 7, then returns with `pipe_col` = 14 → no pulse on the drop, re-arm, and one pulse at the next crossing.
- With TOTAL_W = 2, five passes → `pass_total` sticks at 3 and all five pulses still appear.
- Reset asserted on the cycle `score_inc` = 1 → `score_inc` = 0, `pass_total` = 0, state WAIT on the next cycle.
